// File: rtl/mac_vector_sequencer.sv
// Operand sequencer for a registered multiply-accumulate block: frames (a, b) pair vectors,
// drives the accumulator clear and collects each dot product into a credit-protected result FIFO.
module mac_vector_sequencer #(
   parameter int I_DATA_WIDTH = 18,
   parameter int O_DATA_WIDTH = 44,
   parameter int MAC_LATENCY  = 2,
   parameter int FIFO_DEPTH   = 4,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic signed [I_DATA_WIDTH-1:0] s_a,
   input  logic signed [I_DATA_WIDTH-1:0] s_b,
   input  logic                           s_last,
   output logic signed [I_DATA_WIDTH-1:0] mac_a,
   output logic signed [I_DATA_WIDTH-1:0] mac_b,
   output logic                           mac_clr,
   input  logic signed [O_DATA_WIDTH-1:0] mac_p,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic signed [O_DATA_WIDTH-1:0] m_data,
   output logic [CNT_WIDTH-1:0]           m_count,
   output logic                           busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = $clog2(FIFO_DEPTH + MAC_LATENCY + 1);

   function automatic logic [CNT_WIDTH-1:0] cnt_sat_inc(input logic [CNT_WIDTH-1:0] c);
      if (&c) return c;
      return c + 1'b1;
   endfunction

   logic                           accept;
   logic                           first_flag;
   logic [CNT_WIDTH-1:0]           cnt_q;
   logic [CNT_WIDTH-1:0]           cnt_next;
   logic                           vld_p [MAC_LATENCY];
   logic [CNT_WIDTH-1:0]           cnt_p [MAC_LATENCY];
   logic [OCC_W-1:0]               tag_cnt;
   logic [OCC_W-1:0]               occ;
   logic signed [O_DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic [CNT_WIDTH-1:0]           fifo_cnt  [FIFO_DEPTH];
   logic [PTR_W-1:0]               wr_ptr;
   logic [PTR_W-1:0]               rd_ptr;
   logic [PTR_W:0]                 fill;
   logic                           push;
   logic                           pop;

   // Credit counts results already stored plus those still travelling through the MAC,
   // so a capture can never find the FIFO full.
   always_comb begin
      tag_cnt = '0;
      for (int i = 0; i < MAC_LATENCY; i++) begin
         tag_cnt = tag_cnt + OCC_W'(vld_p[i]);
      end
      occ     = OCC_W'(fill) + tag_cnt;
      s_ready = reset_n && (occ < OCC_W'(FIFO_DEPTH));
   end

   assign accept   = s_valid && s_ready;
   assign cnt_next = first_flag ? CNT_WIDTH'(1) : cnt_sat_inc(cnt_q);

   // Bubbles feed zeros so the free-running accumulator holds its value.
   assign mac_a = accept ? s_a : '0;
   assign mac_b = accept ? s_b : '0;

   assign push    = vld_p[MAC_LATENCY-1];
   assign m_valid = (fill != '0);
   assign pop     = m_valid && m_ready;
   assign m_data  = m_valid ? fifo_data[rd_ptr] : '0;
   assign m_count = m_valid ? fifo_cnt[rd_ptr]  : '0;
   assign busy    = !first_flag || (tag_cnt != '0) || m_valid;

   // Stage p0: acceptance -> clear and tag pipeline; last stage -> FIFO capture
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         first_flag <= 1'b1;
         cnt_q      <= '0;
         mac_clr    <= 1'b0;
         for (int i = 0; i < MAC_LATENCY; i++) begin
            vld_p[i] <= 1'b0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         mac_clr <= accept && first_flag;
         if (accept) begin
            first_flag <= s_last;
            cnt_q      <= cnt_next;
         end
         vld_p[0] <= accept && s_last;
         for (int i = 1; i < MAC_LATENCY; i++) begin
            vld_p[i] <= vld_p[i-1];
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      cnt_p[0] <= cnt_next;
      for (int i = 1; i < MAC_LATENCY; i++) begin
         cnt_p[i] <= cnt_p[i-1];
      end
      // mac_p is sampled before a coincident clear reaches the accumulator
      if (push) begin
         fifo_data[wr_ptr] <= mac_p;
         fifo_cnt[wr_ptr]  <= cnt_p[MAC_LATENCY-1];
      end
   end

endmodule

// File: tb/tb_mac_vector_sequencer.sv
// Scoreboard bench for mac_vector_sequencer with a behavioural MAC attached; expected
// dot products are formed from accepted pairs and compared as results leave the FIFO.
module tb_mac_vector_sequencer;

   localparam int IW = 18;
   localparam int OW = 44;
   localparam int CW = 16;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 s_valid = 1'b0;
   logic                 s_ready;
   logic signed [IW-1:0] s_a = '0;
   logic signed [IW-1:0] s_b = '0;
   logic                 s_last = 1'b0;
   logic signed [IW-1:0] mac_a;
   logic signed [IW-1:0] mac_b;
   logic                 mac_clr;
   logic signed [OW-1:0] mac_p;
   logic                 m_valid;
   logic                 m_ready = 1'b0;
   logic signed [OW-1:0] m_data;
   logic [CW-1:0]        m_count;
   logic                 busy;

   int checks = 0;
   int errors = 0;

   mac_vector_sequencer dut (
      .clk(clk), .reset_n(reset_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
      .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr), .mac_p(mac_p),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_count(m_count),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural MAC: input register, then accumulator with clear on feedback
   logic signed [IW-1:0] a_r = '0;
   logic signed [IW-1:0] b_r = '0;
   logic signed [OW-1:0] acc = '0;
   logic signed [OW-1:0] prod;
   assign prod  = a_r * b_r;
   assign mac_p = acc;
   always @(posedge clk) begin
      a_r <= mac_a;
      b_r <= mac_b;
      acc <= (mac_clr ? '0 : acc) + prod;
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model state
   typedef struct {
      logic signed [OW-1:0] data;
      logic [CW-1:0]        cnt;
   } res_t;
   res_t   sb[$];
   bit     mdl_first = 1'b1;
   longint mdl_sum = 0;
   longint mdl_cnt = 0;
   bit     exp_clr = 1'b0;
   bit     acc_now;
   res_t   r;

   always @(negedge clk) begin
      acc_now = s_valid && s_ready;
      chk("mac_clr", mac_clr, exp_clr);
      if (acc_now) begin
         chk("mac_a", mac_a, s_a);
         chk("mac_b", mac_b, s_b);
      end else begin
         chk("mac_a_idle", mac_a, 0);
         chk("mac_b_idle", mac_b, 0);
      end
      if (m_valid && m_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            r = sb.pop_front();
            chk("m_data", m_data, r.data);
            chk("m_count", m_count, r.cnt);
         end
      end
      if (!reset_n) begin
         mdl_first = 1'b1;
         mdl_sum   = 0;
         mdl_cnt   = 0;
         exp_clr   = 1'b0;
         sb.delete();
      end else begin
         exp_clr = acc_now && mdl_first;
         if (acc_now) begin
            if (mdl_first) begin
               mdl_sum = 0;
               mdl_cnt = 0;
            end
            mdl_sum = mdl_sum + longint'(s_a) * longint'(s_b);
            mdl_cnt = (mdl_cnt == 65535) ? mdl_cnt : mdl_cnt + 1;
            mdl_first = s_last;
            if (s_last) begin
               r.data = OW'(mdl_sum);
               r.cnt  = CW'(mdl_cnt);
               sb.push_back(r);
            end
         end
      end
   end

   // Single driver of m_ready: directed value or random backpressure
   bit rand_en = 1'b0;
   bit m_ready_dir = 1'b0;
   always @(posedge clk) begin
      #2;
      m_ready = rand_en ? ($urandom_range(0, 3) != 0) : m_ready_dir;
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic send(input logic signed [IW-1:0] a, input logic signed [IW-1:0] b,
                       input logic last);
      int n = 0;
      s_a = a; s_b = b; s_last = last; s_valid = 1'b1;
      @(negedge clk);
      while (!s_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!s_ready) chk("send_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic drain();
      int n = 0;
      s_valid = 1'b0;
      while ((sb.size() != 0 || m_valid) && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_empty", sb.size(), 0);
   endtask

   initial begin
      // Reset state, with s_valid asserted to show s_ready is held low
      s_valid = 1'b1; s_a = 18'sd9; s_b = 18'sd9; s_last = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_count", m_count, 0);
      chk("rst_mac_clr", mac_clr, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      idle(2);

      // Three-pair vector with latency check on m_valid
      m_ready_dir = 1'b1;
      idle(1);
      send(18'sd1, 18'sd2, 1'b0);
      send(18'sd3, 18'sd4, 1'b0);
      send(18'sd5, 18'sd6, 1'b1);
      s_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("t1_m_valid_timing", m_valid, (k == 3) ? 1 : 0);
         if (k == 3) begin
            chk("t1_m_data", m_data, 44);
            chk("t1_m_count", m_count, 3);
         end
      end
      @(posedge clk); #1;
      drain();
      @(negedge clk);
      chk("t1_busy_idle", busy, 0);
      @(posedge clk); #1;

      // Extreme negative operands and sign extension
      send(-18'sd131072, -18'sd131072, 1'b1);
      send(-18'sd3, 18'sd7, 1'b1);
      drain();

      // Back-to-back vectors, no bubble
      send(18'sd2, 18'sd3, 1'b1);
      send(18'sd4, 18'sd5, 1'b0);
      send(18'sd1, 18'sd1, 1'b1);
      drain();

      // Backpressure: FIFO plus in-flight credit caps at four results
      m_ready_dir = 1'b0;
      idle(1);
      for (int k = 1; k <= 4; k++) send(18'(k), 18'sd1, 1'b1);
      s_a = 18'sd5; s_b = 18'sd1; s_last = 1'b1; s_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("t4_s_ready_low", s_ready, 0);
         chk("t4_hold_valid", m_valid, 1);
         chk("t4_hold_data", m_data, 1);
      end
      @(posedge clk); #1;
      m_ready_dir = 1'b1;
      send(18'sd5, 18'sd1, 1'b1);
      drain();

      // Gap inside a vector
      send(18'sd2, 18'sd2, 1'b0);
      s_valid = 1'b0;
      @(negedge clk);
      chk("t5_busy_open", busy, 1);
      @(posedge clk); #1;
      idle(2);
      send(18'sd3, 18'sd3, 1'b1);
      drain();

      // Reset mid-vector discards the partial sum
      send(18'sd1, 18'sd1, 1'b0);
      send(18'sd2, 18'sd2, 1'b0);
      s_valid = 1'b0;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("t6_busy_after_reset", busy, 0);
      @(posedge clk); #1;
      send(18'sd7, 18'sd1, 1'b1);
      drain();

      // Random vectors, bubbles and backpressure
      rand_en = 1'b1;
      for (int v = 0; v < 40; v++) begin
         int len = $urandom_range(1, 6);
         for (int e = 0; e < len; e++) begin
            send(18'($urandom), 18'($urandom), (e == len - 1));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         end
      end
      drain();
      rand_en = 1'b0;
      idle(3);
      @(negedge clk);
      chk("final_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
